fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch responder for the control unit: on an inst_fetch request it runs one
//  read transaction on the instruction bus (address channel, then data channel, valid/ready),
//  returns the instruction with its PC, and advances the PC. It sits between control_unit
//  and instruction memory, and owns the architectural PC register.
// PARAMETERS
//  PC_WIDTH    32   width of the PC and the bus address
//  INST_WIDTH  32   width of the instruction and the bus data
//  RESET_PC    0    PC value loaded at reset
// PORTS
//  clk              in   1           clock; all logic on posedge
//  rst              in   1           synchronous reset, active-low
//  inst_fetch       in   1           fetch request from control unit; sampled only in IDLE
//  pc_load          in   1           load pc_load_val as the next fetch PC
//  pc_load_val      in   PC_WIDTH    jump/branch target
//  inst             out  INST_WIDTH  last fetched instruction; holds until next fetch completes
//  inst_pc          out  PC_WIDTH    address inst was fetched from
//  inst_valid       out  1           1-cycle pulse: inst/inst_pc updated
//  pc               out  PC_WIDTH    current PC (next fetch address)
//  busy             out  1           1 while state != IDLE
//  fetch_misaligned out  1           1-cycle pulse on a misaligned fetch attempt (see CONFIGURATION)
//  ir_addr_valid    out  1           address channel valid
//  ir_addr_ready    in   1           address channel ready
//  ir_addr          out  PC_WIDTH    read address
//  ir_data_valid    in   1           data channel valid
//  ir_data_ready    out  1           data channel ready
//  ir_data          in   INST_WIDTH  read data
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE, pc=RESET_PC, inst=0, inst_pc=0, inst_valid=0,
//    busy=0, fetch_misaligned=0, ir_addr_valid=0, ir_data_ready=0, ir_addr=0, pending load cleared.
//    Reset mid-transaction abandons it; no inst_valid results from it.
//  - FSM: IDLE -> ADDR on inst_fetch; ADDR -> DATA on ir_addr_valid&&ir_addr_ready;
//    DATA -> IDLE on ir_data_valid&&ir_data_ready.
//  - IDLE: ir_addr_valid=0, ir_data_ready=0. Entering ADDR registers ir_addr.
//  - ADDR: ir_addr_valid=1; ir_addr held stable until handshake. DATA: ir_data_ready=1.
//  - Bus outputs and inst_valid are registered. ir_data_valid is ignored outside DATA.
//  - On data handshake: inst<=ir_data, inst_pc<=fetch address, pc<=fetch address+4
//    (mod 2^PC_WIDTH, wraps to 0), inst_valid pulses the next cycle.
//  - Latency with a zero-wait bus (addr_ready=1, data_valid in the cycle after the addr
//    handshake): inst_fetch at cycle 0 -> ir_addr_valid at cycle 1 -> data at cycle 2 ->
//    inst_valid at cycle 3. Back-to-back fetch: the next inst_fetch is accepted in the
//    cycle inst_valid is high.
//  - pc_load in IDLE: pc<=pc_load_val. If pc_load and inst_fetch are in the same IDLE cycle,
//    the fetch uses pc_load_val and pc ends at pc_load_val+4.
//  - pc_load while busy: the target is latched as pending (a later load overwrites it). At
//    the data handshake, pc<=pending target instead of +4; inst_pc is still the old address.
//  - inst_fetch while busy is ignored (not queued).
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined: inst_fetch in IDLE with the fetch address[1:0]!=0
//    starts no bus transaction, stays in IDLE, pulses fetch_misaligned for 1 cycle
//    (registered), and leaves pc and inst unchanged.
//  Not defined: fetch_misaligned is tied 0; ir_addr[1:0] is forced to 0; pc still
//    advances by +4 from the unaligned value.
// TESTING
//  1 Reset with RESET_PC=0, zero-wait memory returning 0x00000013 at 0x0; pulse inst_fetch
//    -> ir_addr=0x0, inst=0x13, inst_pc=0x0, inst_valid at cycle 3, pc=0x4.
//  2 ir_addr_ready held low 5 cycles, data_valid delayed 3 cycles -> ir_addr stays stable,
//    exactly one inst_valid, busy high throughout.
//  3 pc_load=1 with pc_load_val=0x100 in the same cycle as inst_fetch -> ir_addr=0x100,
//    final pc=0x104.
//  4 pc_load with pc_load_val=0x200 during DATA of a fetch at 0x8 -> inst_pc=0x8, pc=0x200;
//    next fetch addresses 0x200.
//  5 rst low during ADDR, then ir_data_valid pulsed -> no inst_valid, pc=RESET_PC,
//    ir_addr_valid=0. Also pc=0xFFFFFFFC fetch -> pc wraps to 0x0.
//  6 FETCH_MISALIGN_CHECK_EN, pc_load_val=0x102, then inst_fetch -> no ir_addr_valid,
//    fetch_misaligned pulse, pc=0x102.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch over a valid/ready read bus; owns the PC.
// Optional FETCH_MISALIGN_CHECK_EN rejects fetches from addresses that are not word aligned.
module fetch_unit #(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_fetch,
  input  logic                  pc_load,
  input  logic [PC_WIDTH-1:0]   pc_load_val,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc,
  output logic                  inst_valid,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  busy,
  output logic                  fetch_misaligned,
  output logic                  ir_addr_valid,
  input  logic                  ir_addr_ready,
  output logic [PC_WIDTH-1:0]   ir_addr,
  input  logic                  ir_data_valid,
  output logic                  ir_data_ready,
  input  logic [INST_WIDTH-1:0] ir_data
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              state, next_state;
  logic [PC_WIDTH-1:0] sel_addr, fetch_addr, pending_pc, next_pc;
  logic                pending_valid;
  logic                addr_hs, data_hs, start, misalign_hit;
  logic                addr_valid_d, data_ready_d;

  // A same-cycle load redirects the fetch that starts in this cycle.
  assign sel_addr = pc_load ? pc_load_val : pc;
  assign addr_hs  = (state == ADDR) && ir_addr_valid && ir_addr_ready;
  assign data_hs  = (state == DATA) && ir_data_valid && ir_data_ready;
  assign busy     = (state != IDLE);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_hit = (state == IDLE) && inst_fetch && (sel_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst) fetch_misaligned <= 1'b0;
    else      fetch_misaligned <= misalign_hit;
  end
`else
  assign misalign_hit     = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

  assign start = (state == IDLE) && inst_fetch && !misalign_hit;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start)   next_state = ADDR;
      ADDR:    if (addr_hs) next_state = DATA;
      DATA:    if (data_hs) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bus strobes are registered copies of the state being entered.
  always_comb begin
    addr_valid_d = (next_state == ADDR);
    data_ready_d = (next_state == DATA);
    next_pc      = fetch_addr + PC_WIDTH'(4);
    if (pc_load)            next_pc = pc_load_val;
    else if (pending_valid) next_pc = pending_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc            <= RESET_PC;
      inst          <= '0;
      inst_pc       <= '0;
      inst_valid    <= 1'b0;
      ir_addr_valid <= 1'b0;
      ir_data_ready <= 1'b0;
      ir_addr       <= '0;
      fetch_addr    <= '0;
      pending_valid <= 1'b0;
      pending_pc    <= '0;
    end else begin
      inst_valid    <= data_hs;
      ir_addr_valid <= addr_valid_d;
      ir_data_ready <= data_ready_d;
      if (start) begin
        fetch_addr <= sel_addr;
        ir_addr    <= {sel_addr[PC_WIDTH-1:2], 2'b00};
      end
      if (state == IDLE) begin
        if (pc_load) pc <= pc_load_val;
      end else if (data_hs) begin
        inst          <= ir_data;
        inst_pc       <= fetch_addr;
        pc            <= next_pc;
        pending_valid <= 1'b0;
      end else if (pc_load) begin
        pending_valid <= 1'b1;
        pending_pc    <= pc_load_val;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table plus hand sequences against a delay-configurable memory responder.
// Expected fetch results go into a scoreboard queue and are popped on each inst_valid.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_fetch, pc_load;
  logic [31:0] pc_load_val;
  logic [31:0] inst, inst_pc, pc, ir_addr, ir_data;
  logic        inst_valid, busy, fetch_misaligned;
  logic        ir_addr_valid, ir_addr_ready, ir_data_valid, ir_data_ready;
  logic        resp_addr_ready, resp_data_valid, force_dv;

  int          total = 0;
  int          bad = 0;
  int          addr_delay, data_delay;
  logic [31:0] captured_addr;
  int          addr_changes;

  typedef struct {
    bit          load;
    logic [31:0] load_val;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    int          addr_delay;
    int          data_delay;
    bit          mid_load;
    logic [31:0] mid_val;
    bit          busy_fetch;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  assign ir_addr_ready = resp_addr_ready;
  assign ir_data_valid = resp_data_valid | force_dv;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .inst_fetch      (inst_fetch),
    .pc_load         (pc_load),
    .pc_load_val     (pc_load_val),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_valid      (inst_valid),
    .pc              (pc),
    .busy            (busy),
    .fetch_misaligned(fetch_misaligned),
    .ir_addr_valid   (ir_addr_valid),
    .ir_addr_ready   (ir_addr_ready),
    .ir_addr         (ir_addr),
    .ir_data_valid   (ir_data_valid),
    .ir_data_ready   (ir_data_ready),
    .ir_data         (ir_data)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a << 8) | 32'h13;
  endfunction

  // Memory responder: stalls each channel for the configured number of cycles.
  initial begin
    int          acnt = 0;
    int          dcnt = 0;
    bit          addr_seen = 1'b0;
    logic [31:0] first_addr = '0;
    resp_addr_ready = 1'b0;
    resp_data_valid = 1'b0;
    ir_data         = 32'hDEADBEEF;
    captured_addr   = '0;
    addr_changes    = 0;
    forever begin
      @(negedge clk);
      if (ir_addr_valid) begin
        if (!addr_seen) begin
          first_addr = ir_addr;
          addr_seen  = 1'b1;
        end else if (ir_addr !== first_addr) begin
          addr_changes++;
        end
        if (acnt < addr_delay) begin
          resp_addr_ready = 1'b0;
          acnt++;
        end else begin
          resp_addr_ready = 1'b1;
          captured_addr   = ir_addr;
        end
      end else begin
        resp_addr_ready = 1'b0;
        acnt            = 0;
        addr_seen       = 1'b0;
      end
      if (ir_data_ready) begin
        if (dcnt < data_delay) begin
          resp_data_valid = 1'b0;
          ir_data         = 32'hDEADBEEF;
          dcnt++;
        end else begin
          resp_data_valid = 1'b1;
          ir_data         = mem(captured_addr);
        end
      end else begin
        resp_data_valid = 1'b0;
        ir_data         = 32'hDEADBEEF;
        dcnt            = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Waits for inst_valid, optionally injecting a load during DATA or a fetch while busy.
  task automatic waitValid(input bit mid_load, input logic [31:0] mid_val,
                           input bit busy_fetch, output int lat);
    bit   done_mid   = 1'b0;
    int   busy_drops = 0;
    exp_t e;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      inst_fetch = busy_fetch && (i == 2);
      pc_load    = 1'b0;
      if (mid_load && !done_mid && ir_data_ready) begin
        pc_load     = 1'b1;
        pc_load_val = mid_val;
        done_mid    = 1'b1;
      end
      if (inst_valid) begin
        lat = i;
        break;
      end
      if (!busy) busy_drops++;
    end
    if (lat < 0) begin
      checkOutput("valid_timeout", 32'd0, 32'd1);
      sb.delete();
    end else if (sb.size() == 0) begin
      checkOutput("unexpected_valid", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput("inst", inst, e.inst);
      checkOutput("inst_pc", inst_pc, e.addr);
      checkOutput("pc_after", pc, e.pc);
    end
    checkOutput("busy_during_fetch", busy_drops, 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int   lat;
    int   extra = 0;
    int   changes_before;
    exp_t e;
    @(negedge clk);
    addr_delay     = v.addr_delay;
    data_delay     = v.data_delay;
    inst_fetch     = 1'b1;
    pc_load        = v.load;
    pc_load_val    = v.load_val;
    changes_before = addr_changes;
    e.addr = v.exp_addr;
    e.inst = mem(v.exp_addr & 32'hFFFF_FFFC);
    e.pc   = v.exp_pc;
    sb.push_back(e);
    waitValid(v.mid_load, v.mid_val, v.busy_fetch, lat);
    checkOutput("latency", lat, 3 + v.addr_delay + v.data_delay);
    checkOutput("bus_addr", captured_addr, v.exp_addr & 32'hFFFF_FFFC);
    checkOutput("addr_stable", addr_changes - changes_before, 32'd0);
    repeat (4) begin
      @(negedge clk);
      if (inst_valid) extra++;
      if (busy) extra++;
    end
    checkOutput("idle_after_fetch", extra, 32'd0);
  endtask

  initial begin
    int   lat;
    int   anomalies;
    exp_t e;
    vec_t u;

    vecs[0] = '{1'b0, 32'h0,        32'h0,        32'h4,   0, 0, 1'b0, 32'h0,   1'b0};
    vecs[1] = '{1'b0, 32'h0,        32'h4,        32'h8,   5, 3, 1'b0, 32'h0,   1'b0};
    vecs[2] = '{1'b0, 32'h0,        32'h8,        32'h200, 0, 3, 1'b1, 32'h200, 1'b0};
    vecs[3] = '{1'b0, 32'h0,        32'h200,      32'h204, 0, 0, 1'b0, 32'h0,   1'b0};
    vecs[4] = '{1'b1, 32'h100,      32'h100,      32'h104, 0, 0, 1'b0, 32'h0,   1'b0};
    vecs[5] = '{1'b0, 32'h0,        32'h104,      32'h108, 1, 2, 1'b0, 32'h0,   1'b1};
    vecs[6] = '{1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,   0, 0, 1'b0, 32'h0,   1'b0};
    vecs[7] = '{1'b0, 32'h0,        32'h0,        32'h4,   0, 1, 1'b0, 32'h0,   1'b0};

    rst         = 1'b0;
    inst_fetch  = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    force_dv    = 1'b0;
    addr_delay  = 0;
    data_delay  = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_inst", inst, 32'h0);
    checkOutput("reset_inst_pc", inst_pc, 32'h0);
    checkOutput("reset_inst_valid", inst_valid, 32'h0);
    checkOutput("reset_busy", busy, 32'h0);
    checkOutput("reset_addr_valid", ir_addr_valid, 32'h0);
    checkOutput("reset_data_ready", ir_data_ready, 32'h0);
    checkOutput("reset_ir_addr", ir_addr, 32'h0);
    checkOutput("reset_misaligned", fetch_misaligned, 32'h0);
    rst = 1'b1;

    for (int k = 0; k < 8; k++) applyStimulus(vecs[k]);

    // Back-to-back: the next fetch is raised in the same cycle inst_valid is seen.
    @(negedge clk);
    addr_delay = 0;
    data_delay = 0;
    inst_fetch = 1'b1;
    e.addr = 32'h4; e.inst = mem(32'h4); e.pc = 32'h8;
    sb.push_back(e);
    waitValid(1'b0, 32'h0, 1'b0, lat);
    checkOutput("b2b_first_latency", lat, 32'd3);
    inst_fetch = 1'b1;
    e.addr = 32'h8; e.inst = mem(32'h8); e.pc = 32'hC;
    sb.push_back(e);
    @(negedge clk);
    inst_fetch = 1'b0;
    checkOutput("b2b_addr_valid", ir_addr_valid, 32'h1);
    checkOutput("b2b_addr", ir_addr, 32'h8);
    waitValid(1'b0, 32'h0, 1'b0, lat);
    checkOutput("b2b_second_latency", lat, 32'd2);

    // Reset while the address channel is stalled abandons the fetch.
    @(negedge clk);
    addr_delay = 10;
    inst_fetch = 1'b1;
    @(negedge clk);
    inst_fetch = 1'b0;
    checkOutput("rst_test_addr_valid", ir_addr_valid, 32'h1);
    checkOutput("rst_test_addr", ir_addr, 32'hC);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst        = 1'b1;
    addr_delay = 0;
    force_dv   = 1'b1;
    checkOutput("rst_mid_addr_valid", ir_addr_valid, 32'h0);
    checkOutput("rst_mid_pc", pc, 32'h0);
    checkOutput("rst_mid_inst", inst, 32'h0);
    anomalies = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) force_dv = 1'b0;
      if (inst_valid || busy || ir_addr_valid || ir_data_ready) anomalies++;
      @(negedge clk);
    end
    checkOutput("rst_mid_quiet", anomalies, 32'd0);

`ifdef FETCH_MISALIGN_CHECK_EN
    pc_load     = 1'b1;
    pc_load_val = 32'h102;
    @(negedge clk);
    pc_load    = 1'b0;
    inst_fetch = 1'b1;
    @(negedge clk);
    inst_fetch = 1'b0;
    checkOutput("misalign_pulse", fetch_misaligned, 32'h1);
    checkOutput("misalign_no_addr_valid", ir_addr_valid, 32'h0);
    checkOutput("misalign_not_busy", busy, 32'h0);
    checkOutput("misalign_pc", pc, 32'h102);
    @(negedge clk);
    checkOutput("misalign_pulse_end", fetch_misaligned, 32'h0);
    checkOutput("misalign_still_idle", ir_addr_valid, 32'h0);
`else
    // Without the check, an unaligned fetch goes out word aligned and pc steps by 4.
    u = '{1'b1, 32'h102, 32'h102, 32'h106, 0, 0, 1'b0, 32'h0, 1'b0};
    applyStimulus(u);
    checkOutput("unaligned_misaligned_low", fetch_misaligned, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
